// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if
//   Signal bundle between one 4x4 keypad scan controller and the logic around it.
//   master : the keypad/host side (drives scan_en and row; receives the scan outputs)
//   slave  : the scan controller (drives col and the key report)
//   scan_en   1  1 = scanning enabled, 0 = keypad idle
//   row       4  keypad rows, active-high; row[3]=R0 .. row[0]=R3
//   col       4  one-hot column drive, col[c] drives column Cc
//   key_code  4  {row_idx, col_idx} of the last accepted key
//   key_valid 1  one-cycle strobe when key_code is updated
//   key_held  1  an accepted key has not yet been released
interface keypad_scan_ctrl_if;
  logic       scan_en;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output scan_en, row,
    input  col, key_code, key_valid, key_held
  );

  modport slave (
    input  scan_en, row,
    output col, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scan sequencer for one 4x4 keypad. Drives one column at a time, samples the rows
//   once per column dwell, debounces presses and releases, and reports each accepted
//   press as a key code with a one-cycle strobe.
// Parameters
//   SCAN_DIV  clk cycles per column dwell (>= 2)
//   DEBOUNCE  identical samples needed to accept a press or a release (>= 1)
// Ports
//   clk   system clock, rising edge
//   nRst  synchronous reset, active-low
//   kp    keypad_scan_ctrl_if.slave (scan_en, row in; col, key_code, key_valid, key_held out)
//
// state   | meaning
// --------+-----------------------------------------------------------------
// SCAN    | rotating columns, looking for a single-key sample
// CONFIRM | column frozen, counting samples that match the candidate key
// ACCEPT  | one cycle: publish key_code, strobe key_valid, raise key_held
// HELD    | column frozen, counting consecutive no-key samples for release
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 100,
  parameter int DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               nRst,
  keypad_scan_ctrl_if.slave  kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE);

  typedef enum logic [1:0] {S_SCAN, S_CONFIRM, S_ACCEPT, S_HELD} state_e;

  state_e          state_q, state_d;
  logic [3:0]      col_q, col_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;

  logic            sample;
  logic            row_valid;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic [3:0]      col_rot;
  logic [CW-1:0]   cnt_inc;

  always_comb begin
    row_idx = 2'd0;
    case (kp.row)
      4'b1000: row_idx = 2'd0;
      4'b0100: row_idx = 2'd1;
      4'b0010: row_idx = 2'd2;
      4'b0001: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    col_idx = 2'd0;
    case (col_q)
      4'b0001: col_idx = 2'd0;
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  assign row_valid = $onehot(kp.row);
  assign sample    = (dwell_q == DWELL_LAST);
  assign col_rot   = {col_q[2:0], col_q[3]};
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;

    if (!kp.scan_en) begin
      state_d = S_SCAN;
      col_d   = 4'b0000;
      dwell_d = '0;
      cnt_d   = '0;
      held_d  = 1'b0;
    end else if (col_q == 4'b0000) begin
      // First enabled cycle after an idle period: restart exactly like reset.
      col_d   = 4'b0001;
      dwell_d = '0;
    end else begin
      dwell_d = sample ? '0 : dwell_q + 1'b1;
      case (state_q)
        S_SCAN: begin
          if (sample) begin
            if (row_valid) begin
              cand_d  = {row_idx, col_idx};
              cnt_d   = CW'(1);
              state_d = (DEBOUNCE == 1) ? S_ACCEPT : S_CONFIRM;
            end else begin
              col_d = col_rot;
            end
          end
        end
        S_CONFIRM: begin
          if (sample) begin
            // Column is frozen, so matching the row index matches the whole code.
            if (row_valid && (row_idx == cand_q[3:2])) begin
              cnt_d = cnt_inc;
              if (cnt_inc == DEB_TARGET) state_d = S_ACCEPT;
            end else begin
              state_d = S_SCAN;
              col_d   = col_rot;
              cnt_d   = '0;
            end
          end
        end
        S_ACCEPT: begin
          code_d  = cand_q;
          valid_d = 1'b1;
          held_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_HELD;
        end
        S_HELD: begin
          if (sample) begin
            if (kp.row == 4'b0000) begin
              cnt_d = cnt_inc;
              if (cnt_inc == DEB_TARGET) begin
                held_d  = 1'b0;
                col_d   = col_rot;
                cnt_d   = '0;
                state_d = S_SCAN;
              end
            end else begin
              cnt_d = '0;
            end
          end
        end
        default: state_d = S_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= S_SCAN;
      col_q   <= 4'b0001;
      dwell_q <= '0;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  localparam int P_SCAN    = 0;
  localparam int P_CONFIRM = 1;
  localparam int P_ACCEPT  = 2;
  localparam int P_HELD    = 3;

  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  keypad_scan_ctrl_if kp();

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk  (clk),
    .nRst (nRst),
    .kp   (kp)
  );

  // Keypad emulation: either a fixed row pattern, or a key that closes only
  // while its column is driven.
  logic       row_mode;
  logic [3:0] row_direct;
  logic [3:0] press_col;
  logic [3:0] press_row;

  always_comb begin
    if (row_mode) kp.row = ((kp.col & press_col) != 4'b0000) ? press_row : 4'b0000;
    else          kp.row = row_direct;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulse_cnt = 0;
  bit run_cmp  = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: column as an index 0..3 (-1 = idle), dwell as a modulo count.
  int         m_col = 0;
  int         m_dwell = 0;
  int         m_phase = P_SCAN;
  int         m_cnt = 0;
  int         m_cand = 0;
  logic [3:0] m_code = 4'h0;
  bit         m_valid = 1'b0;
  bit         m_held = 1'b0;
  int         nb;
  int         ri;
  bit         smp;

  always @(posedge clk) begin
    cyc++;
    nb = $countones(kp.row);
    ri = kp.row[3] ? 0 : kp.row[2] ? 1 : kp.row[1] ? 2 : 3;
    m_valid = 1'b0;
    if (!nRst) begin
      m_col = 0; m_dwell = 0; m_phase = P_SCAN; m_cnt = 0; m_code = 4'h0; m_held = 1'b0;
    end else if (!kp.scan_en) begin
      m_col = -1; m_dwell = 0; m_phase = P_SCAN; m_cnt = 0; m_held = 1'b0;
    end else if (m_col < 0) begin
      m_col = 0; m_dwell = 0;
    end else begin
      smp = (m_dwell == SCAN_DIV - 1);
      m_dwell = (m_dwell + 1) % SCAN_DIV;
      if (m_phase == P_ACCEPT) begin
        m_code = 4'(m_cand); m_valid = 1'b1; m_held = 1'b1; m_cnt = 0; m_phase = P_HELD;
      end else if (smp) begin
        case (m_phase)
          P_SCAN:
            if (nb == 1) begin
              m_cand = ri * 4 + m_col; m_cnt = 1;
              m_phase = (DEBOUNCE == 1) ? P_ACCEPT : P_CONFIRM;
            end else m_col = (m_col + 1) % 4;
          P_CONFIRM:
            if (nb == 1 && (ri * 4 + m_col) == m_cand) begin
              m_cnt++;
              if (m_cnt == DEBOUNCE) m_phase = P_ACCEPT;
            end else begin
              m_phase = P_SCAN; m_col = (m_col + 1) % 4; m_cnt = 0;
            end
          P_HELD:
            if (nb == 0) begin
              m_cnt++;
              if (m_cnt == DEBOUNCE) begin
                m_held = 1'b0; m_col = (m_col + 1) % 4; m_phase = P_SCAN; m_cnt = 0;
              end
            end else m_cnt = 0;
          default: ;
        endcase
      end
    end
  end

  logic [3:0] exp_col;
  bit         prev_valid = 1'b0;

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) pulse_cnt++;
    if (run_cmp) begin
      exp_col = (m_col < 0) ? 4'b0000 : 4'(1 << m_col);
      chk("col",       {4'h0, kp.col},      {4'h0, exp_col});
      chk("key_code",  {4'h0, kp.key_code}, {4'h0, m_code});
      chk("key_valid", {7'h0, kp.key_valid}, {7'h0, m_valid});
      chk("key_held",  {7'h0, kp.key_held},  {7'h0, m_held});
      chk("valid_back_to_back", {7'h0, prev_valid & kp.key_valid}, 8'h0);
    end
    prev_valid = kp.key_valid;
  end

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int n);
    go(n);
    @(negedge clk);
  endtask

  int p0;

  initial begin
    nRst = 1'b0;
    kp.scan_en = 1'b1;
    row_mode = 1'b0;
    row_direct = 4'b1000;
    press_col = 4'b0000;
    press_row = 4'b0000;

    // Reset for two cycles with a row asserted.
    go(1);
    run_cmp = 1'b1;
    at_neg(2);
    chk("rst_col",   {4'h0, kp.col}, 8'h01);
    chk("rst_code",  {4'h0, kp.key_code}, 8'h00);
    chk("rst_valid", {7'h0, kp.key_valid}, 8'h00);
    chk("rst_held",  {7'h0, kp.key_held}, 8'h00);
    chk("rst_no_pulse", 8'(pulse_cnt), 8'h00);

    // Press R0 C1 (last reset edge = 2; first sample edge = 10; strobe at 19).
    nRst = 1'b1;
    row_mode = 1'b1;
    press_col = 4'b0010;
    press_row = 4'b1000;
    p0 = pulse_cnt;
    at_neg(18);
    chk("press1_no_early", 8'(pulse_cnt - p0), 8'h00);
    at_neg(19);
    chk("press1_valid", {7'h0, kp.key_valid}, 8'h01);
    chk("press1_code",  {4'h0, kp.key_code}, 8'h01);
    chk("press1_held",  {7'h0, kp.key_held}, 8'h01);
    at_neg(41);
    chk("press1_one_pulse", 8'(pulse_cnt - p0), 8'h01);
    chk("press1_still_held", {7'h0, kp.key_held}, 8'h01);

    // Release: zero samples at 46, 50, 54.
    go(42);
    row_mode = 1'b0;
    row_direct = 4'b0000;
    at_neg(53);
    chk("rel_held_before", {7'h0, kp.key_held}, 8'h01);
    chk("rel_col_before",  {4'h0, kp.col}, 8'h02);
    at_neg(54);
    chk("rel_held_fall", {7'h0, kp.key_held}, 8'h00);
    chk("rel_col_adv",   {4'h0, kp.col}, 8'h04);
    at_neg(58);
    chk("rel_scan_resume", {4'h0, kp.col}, 8'h08);

    // Bounce: row 0010 during one dwell of col 0001 only.
    go(60);
    nRst = 1'b0;
    row_direct = 4'b0010;
    p0 = pulse_cnt;
    go(61);
    nRst = 1'b1;
    go(65);
    row_direct = 4'b0000;
    at_neg(68);
    chk("bounce_col_frozen", {4'h0, kp.col}, 8'h01);
    at_neg(69);
    chk("bounce_col_0010", {4'h0, kp.col}, 8'h02);
    at_neg(73);
    chk("bounce_col_0100", {4'h0, kp.col}, 8'h04);
    chk("bounce_no_pulse", 8'(pulse_cnt - p0), 8'h00);

    // Two rows at once: never accepted, columns keep rotating.
    row_direct = 4'b1001;
    at_neg(77);
    chk("multi_col_1000", {4'h0, kp.col}, 8'h08);
    at_neg(81);
    chk("multi_col_0001", {4'h0, kp.col}, 8'h01);
    at_neg(113);
    chk("multi_no_pulse", 8'(pulse_cnt - p0), 8'h00);
    chk("multi_not_held", {7'h0, kp.key_held}, 8'h00);

    // Press R3 C2 (last reset edge 114; sample edge 126; strobe at 135).
    go(113);
    nRst = 1'b0;
    row_direct = 4'b0000;
    row_mode = 1'b1;
    press_col = 4'b0100;
    press_row = 4'b0001;
    go(114);
    nRst = 1'b1;
    at_neg(134);
    chk("press2_no_early", {7'h0, kp.key_valid}, 8'h00);
    at_neg(135);
    chk("press2_valid", {7'h0, kp.key_valid}, 8'h01);
    chk("press2_code",  {4'h0, kp.key_code}, 8'h0e);

    // One-cycle reset while held.
    go(144);
    nRst = 1'b0;
    go(145);
    nRst = 1'b1;
    @(negedge clk);
    chk("hrst_held",  {7'h0, kp.key_held}, 8'h00);
    chk("hrst_valid", {7'h0, kp.key_valid}, 8'h00);
    chk("hrst_col",   {4'h0, kp.col}, 8'h01);
    at_neg(166);
    chk("press3_valid", {7'h0, kp.key_valid}, 8'h01);
    chk("press3_code",  {4'h0, kp.key_code}, 8'h0e);

    // One-cycle scan_en=0 while held.
    go(175);
    kp.scan_en = 1'b0;
    go(176);
    kp.scan_en = 1'b1;
    @(negedge clk);
    chk("dis_col",   {4'h0, kp.col}, 8'h00);
    chk("dis_held",  {7'h0, kp.key_held}, 8'h00);
    chk("dis_valid", {7'h0, kp.key_valid}, 8'h00);
    chk("dis_code_kept", {4'h0, kp.key_code}, 8'h0e);
    at_neg(177);
    chk("reen_col", {4'h0, kp.col}, 8'h01);

    // scan_en=0 on the would-be strobe edge (198) suppresses the strobe.
    p0 = pulse_cnt;
    go(197);
    kp.scan_en = 1'b0;
    go(198);
    kp.scan_en = 1'b1;
    @(negedge clk);
    chk("pend_no_valid", {7'h0, kp.key_valid}, 8'h00);
    chk("pend_col_idle", {4'h0, kp.col}, 8'h00);
    at_neg(205);
    chk("pend_no_pulse", 8'(pulse_cnt - p0), 8'h00);
    at_neg(220);
    chk("press4_valid", {7'h0, kp.key_valid}, 8'h01);

    at_neg(225);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
